// File: rtl/switch_debounce4.sv
// ---------------------------------------------------------------------------
// switch_debounce4
//
// Purpose:
//   Four-channel switch/button conditioner that sits in front of the 4:3
//   ones-count encoder. Each raw level is brought into the clock domain by a
//   two-flop synchroniser. A per-channel stability counter then accepts a new
//   level only after the synchronised input has disagreed with the current
//   debounced level for DEBOUNCE_TICKS consecutive sample ticks. o_changed
//   strobes for one cycle whenever any debounced output moves, so downstream
//   logic knows when to latch the encoded count.
//
// Parameters:
//   DEBOUNCE_TICKS  consecutive qualifying ticks needed to accept a new level
//                   (legal range 2..65535)
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset, clears every flop
//   i_tick     in   sample enable, counters only advance on ticked edges
//   i_a_raw    in   raw asynchronous level, channel A
//   i_b_raw    in   raw asynchronous level, channel B
//   i_c_raw    in   raw asynchronous level, channel C
//   i_d_raw    in   raw asynchronous level, channel D
//   o_a        out  debounced level, channel A (registered)
//   o_b        out  debounced level, channel B (registered)
//   o_c        out  debounced level, channel C (registered)
//   o_d        out  debounced level, channel D (registered)
//   o_changed  out  one-cycle strobe, high in the cycle any of o_a..o_d moves
// ---------------------------------------------------------------------------
module switch_debounce4 #(
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_a_raw,
  input  logic i_b_raw,
  input  logic i_c_raw,
  input  logic i_d_raw,
  output logic o_a,
  output logic o_b,
  output logic o_c,
  output logic o_d,
  output logic o_changed
);

  // The counter only ever holds 0..DEBOUNCE_TICKS-1, so clog2 bits suffice.
  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  // Channel index 0..3 maps to A..D throughout.
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_level;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_update;
  logic          r_changed;

  assign w_raw = {i_d_raw, i_c_raw, i_b_raw, i_a_raw};

  // A channel accepts its new level on the ticked edge where the counter has
  // already seen DEBOUNCE_TICKS-1 qualifying ticks and the mismatch persists.
  always_comb begin
    w_update = '0;
    for (int i = 0; i < 4; i++) begin
      w_update[i] = (r_sync2[i] != r_level[i]) && i_tick && (r_cnt[i] == CNT_LAST);
    end
  end

  // Two-flop synchroniser per channel; raw levels are fully asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counters and debounced levels. Any edge where the synchronised
  // input agrees with the accepted level clears the count, tick or not, so a
  // short glitch never accumulates across separate bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (w_update[i]) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else if (i_tick) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Shared strobe: simultaneous updates on several channels merge into a
  // single pulse aligned with the new levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_update;
    end
  end

  assign o_a       = r_level[0];
  assign o_b       = r_level[1];
  assign o_c       = r_level[2];
  assign o_d       = r_level[3];
  assign o_changed = r_changed;

endmodule

// File: tb/tb_switch_debounce4.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce4
//
// Purpose:
//   Self-checking bench for switch_debounce4 with DEBOUNCE_TICKS = 4.
//   Every driven edge pushes the expected {D,C,B,A,changed} into a queue;
//   the value is popped and compared once the DUT has reacted to that edge.
// ---------------------------------------------------------------------------
module tb_switch_debounce4;

  localparam int DT = 4;

  logic clk;
  logic rst_n;
  logic tick;
  logic [3:0] raw;
  logic o_a, o_b, o_c, o_d, o_changed;

  int testsRun;
  int testsFailed;
  logic [4:0] expQ [$];

  switch_debounce4 #(.DEBOUNCE_TICKS(DT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (tick),
    .i_a_raw   (raw[0]),
    .i_b_raw   (raw[1]),
    .i_c_raw   (raw[2]),
    .i_d_raw   (raw[3]),
    .o_a       (o_a),
    .o_b       (o_b),
    .o_c       (o_c),
    .o_d       (o_d),
    .o_changed (o_changed)
  );

  // 10-unit free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] observed();
    return {o_d, o_c, o_b, o_a, o_changed};
  endfunction

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got DCBA=%b changed=%b, expected DCBA=%b changed=%b",
               tag, obs[4:1], obs[0], exp[4:1], exp[0]);
    end
  endtask

  // Compare the current outputs without advancing the clock.
  task automatic checkNow(input string tag, input logic [3:0] expOut, input logic expChg);
    expQ.push_back({expOut, expChg});
    checkOutput(tag, observed(), expQ.pop_front());
  endtask

  // Drive one edge worth of stimulus, queue its expected result, then check
  // it just after the edge.
  task automatic applyStimulus(input string tag, input logic [3:0] newRaw, input logic newTick,
                               input logic [3:0] expOut, input logic expChg);
    @(negedge clk);
    raw  = newRaw;
    tick = newTick;
    expQ.push_back({expOut, expChg});
    @(posedge clk);
    #1;
    checkOutput(tag, observed(), expQ.pop_front());
  endtask

  // Clean level change from an idle state with Tick tied high: the new
  // level appears on the (DT+2)-th edge after the raw change, i.e. edge DT+1.
  task automatic stepTo(input string name, input logic [3:0] newRaw,
                        input logic [3:0] prevOut, input logic [3:0] newOut, input int n);
    for (int e = 0; e < n; e++) begin
      applyStimulus($sformatf("%s e%0d", name, e), newRaw, 1'b1,
                    (e >= DT + 1) ? newOut : prevOut, (e == DT + 1));
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    tick  = 1'b0;
    raw   = 4'b0000;

    // Reset state
    #12;
    checkNow("reset", 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick  = 1'b1;
    stepTo("idle", 4'b0000, 4'b0000, 4'b0000, 3);

    // Clean step on B, then release it
    stepTo("stepB", 4'b0010, 4'b0000, 4'b0010, 8);
    stepTo("relB", 4'b0000, 4'b0010, 4'b0000, 8);

    // Glitch of 3 clocks on A is rejected
    for (int e = 0; e < 10; e++) begin
      applyStimulus($sformatf("glitch3 e%0d", e), (e < 3) ? 4'b0001 : 4'b0000, 1'b1,
                    4'b0000, 1'b0);
    end

    // 4-clock pulse on A is accepted, and released 4 ticks after it ends
    for (int e = 0; e < 12; e++) begin
      applyStimulus($sformatf("pulse4 e%0d", e), (e < 4) ? 4'b0001 : 4'b0000, 1'b1,
                    (e >= 5 && e < 9) ? 4'b0001 : 4'b0000, (e == 5 || e == 9));
    end

    // Tick every 3rd clock: ticks at edges 3,6,9,12 after the C change,
    // so C lands on edge 12
    for (int e = 0; e < 15; e++) begin
      applyStimulus($sformatf("tickC e%0d", e), 4'b0100, (e % 3 == 0),
                    (e >= 12) ? 4'b0100 : 4'b0000, (e == 12));
    end
    stepTo("relC", 4'b0000, 4'b0100, 4'b0000, 8);

    // All four channels together: single pulse, no intermediate codes
    stepTo("all", 4'b1111, 4'b0000, 4'b1111, 8);
    stepTo("relAll", 4'b0000, 4'b1111, 4'b0000, 8);

    // Reset mid-count: A settled high, D halfway through its count
    stepTo("setA", 4'b0001, 4'b0000, 4'b0001, 8);
    for (int e = 0; e < 4; e++) begin
      applyStimulus($sformatf("midD e%0d", e), 4'b1001, 1'b1, 4'b0001, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkNow("rstAsync", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    checkNow("rstHeld", 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkNow("rstRel", 4'b0000, 1'b0);
    // Release happened at a negedge, so the next stimulus slot is edge 0
    for (int e = 0; e < 8; e++) begin
      expQ.push_back({((e >= 5) ? 4'b1001 : 4'b0000), (e == 5)});
      @(posedge clk);
      #1;
      checkOutput($sformatf("postRst e%0d", e), observed(), expQ.pop_front());
    end
    stepTo("relAD", 4'b0000, 4'b1001, 4'b0000, 8);

    // Bounce train on D, then settle high
    for (int e = 0; e < 20; e++) begin
      applyStimulus($sformatf("bounce e%0d", e), (e % 2 == 0) ? 4'b1000 : 4'b0000, 1'b1,
                    4'b0000, 1'b0);
    end
    stepTo("settleD", 4'b1000, 4'b0000, 4'b1000, 8);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
